// File: rtl/cluster_collector.sv
// Collects per-pass priority-encoder clusters into one frame of NCL global slots; the last pass is taken straight from the inputs.
// Latency: 1 cycle from the final pass to out_valid. A frame completing while the held frame is unaccepted is dropped.
// Optional macro CLUSTER_DROP_CNT_EN adds an 8-bit saturating drop_cnt output.
module cluster_collector #(
   parameter int NUM_ENCODERS = 2,
   parameter int NUM_PASSES   = 4,
   parameter int SEG_SIZE     = 768,
   parameter int MXADRBITS    = 11,
   parameter int MXCNTBITS    = 3,
   localparam int NCL   = NUM_ENCODERS*NUM_PASSES,
   localparam int PASSW = 3
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              enc_valid,
   input  logic [PASSW-1:0]                  pass_in,
   input  logic [NUM_ENCODERS*MXADRBITS-1:0] adr_in,
   input  logic [NUM_ENCODERS*MXCNTBITS-1:0] cnt_in,
   input  logic [NUM_ENCODERS-1:0]           vpf_in,
   output logic [NCL*MXADRBITS-1:0]          adr_out,
   output logic [NCL*MXCNTBITS-1:0]          cnt_out,
   output logic [NCL-1:0]                    vpf_out,
   output logic [4:0]                        ncl_out,
   output logic                              out_valid,
   input  logic                              out_ready
`ifdef CLUSTER_DROP_CNT_EN
   ,
   output logic [7:0]                        drop_cnt
`endif
);

   // The final pass never needs storage, so only NUM_PASSES-1 working slots per encoder.
   localparam int NWRK = NUM_ENCODERS*(NUM_PASSES-1);

   logic [MXADRBITS-1:0] wrk_adr [NWRK];
   logic [MXCNTBITS-1:0] wrk_cnt [NWRK];
   logic [NWRK-1:0]      wrk_vpf;

   logic [MXADRBITS-1:0] glb_adr [NUM_ENCODERS];

   logic [NCL*MXADRBITS-1:0] nxt_adr;
   logic [NCL*MXCNTBITS-1:0] nxt_cnt;
   logic [NCL-1:0]           nxt_vpf;
   logic [4:0]               nxt_ncl;

   logic pass_ok;
   logic frm_done;
   logic load_out;

   assign pass_ok  = enc_valid && (int'(pass_in) < NUM_PASSES);
   assign frm_done = enc_valid && (int'(pass_in) == NUM_PASSES-1);
   assign load_out = frm_done && (!out_valid || out_ready);

   // Segment offset applies only to found clusters; wraps modulo 2^MXADRBITS.
   always_comb begin
      for (int e = 0; e < NUM_ENCODERS; e++) begin
         glb_adr[e] = adr_in[e*MXADRBITS +: MXADRBITS];
         if (vpf_in[e]) begin
            glb_adr[e] = glb_adr[e] + MXADRBITS'(e*SEG_SIZE);
         end
      end
   end

   always_comb begin
      nxt_adr = '0;
      nxt_cnt = '0;
      nxt_vpf = '0;
      nxt_ncl = '0;
      for (int e = 0; e < NUM_ENCODERS; e++) begin
         for (int p = 0; p < NUM_PASSES; p++) begin
            if (p == NUM_PASSES-1) begin
               nxt_adr[(e*NUM_PASSES+p)*MXADRBITS +: MXADRBITS] = glb_adr[e];
               nxt_cnt[(e*NUM_PASSES+p)*MXCNTBITS +: MXCNTBITS] = cnt_in[e*MXCNTBITS +: MXCNTBITS];
               nxt_vpf[e*NUM_PASSES+p]                          = vpf_in[e];
            end else begin
               nxt_adr[(e*NUM_PASSES+p)*MXADRBITS +: MXADRBITS] = wrk_adr[e*(NUM_PASSES-1)+p];
               nxt_cnt[(e*NUM_PASSES+p)*MXCNTBITS +: MXCNTBITS] = wrk_cnt[e*(NUM_PASSES-1)+p];
               nxt_vpf[e*NUM_PASSES+p]                          = wrk_vpf[e*(NUM_PASSES-1)+p];
            end
         end
      end
      for (int k = 0; k < NCL; k++) begin
         nxt_ncl = nxt_ncl + 5'(nxt_vpf[k]);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         adr_out   <= '0;
         cnt_out   <= '0;
         vpf_out   <= '0;
         ncl_out   <= '0;
         wrk_vpf   <= '0;
         for (int w = 0; w < NWRK; w++) begin
            wrk_adr[w] <= '0;
            wrk_cnt[w] <= '0;
         end
      end else begin
         if (load_out) begin
            out_valid <= 1'b1;
            adr_out   <= nxt_adr;
            cnt_out   <= nxt_cnt;
            vpf_out   <= nxt_vpf;
            ncl_out   <= nxt_ncl;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         // Completion empties the slots whether the frame was loaded or dropped.
         if (frm_done) begin
            wrk_vpf <= '0;
            for (int w = 0; w < NWRK; w++) begin
               wrk_adr[w] <= '0;
               wrk_cnt[w] <= '0;
            end
         end else if (pass_ok) begin
            for (int e = 0; e < NUM_ENCODERS; e++) begin
               for (int p = 0; p < NUM_PASSES-1; p++) begin
                  if (int'(pass_in) == p) begin
                     wrk_adr[e*(NUM_PASSES-1)+p] <= glb_adr[e];
                     wrk_cnt[e*(NUM_PASSES-1)+p] <= cnt_in[e*MXCNTBITS +: MXCNTBITS];
                     wrk_vpf[e*(NUM_PASSES-1)+p] <= vpf_in[e];
                  end
               end
            end
         end
      end
   end

`ifdef CLUSTER_DROP_CNT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         drop_cnt <= '0;
      end else if (frm_done && out_valid && !out_ready && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cluster_collector.sv
// Randomized + directed bench for cluster_collector against a frame-level reference model.
module tb_cluster_collector;
   localparam int NE = 2, NP = 4, SEG = 768, AW = 11, CW = 3, NCL = NE*NP;
   localparam int BNE = 3, BNP = 8, BNCL = BNE*BNP;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic              reset, enc_valid, out_ready, out_valid;
   logic [2:0]        pass_in;
   logic [NE*AW-1:0]  adr_in;
   logic [NE*CW-1:0]  cnt_in;
   logic [NE-1:0]     vpf_in;
   logic [NCL*AW-1:0] adr_out;
   logic [NCL*CW-1:0] cnt_out;
   logic [NCL-1:0]    vpf_out;
   logic [4:0]        ncl_out;

   logic               b_enc_valid, b_out_ready, b_out_valid;
   logic [2:0]         b_pass_in;
   logic [BNE*11-1:0]  b_adr_in;
   logic [BNE*3-1:0]   b_cnt_in;
   logic [BNE-1:0]     b_vpf_in;
   logic [BNCL*11-1:0] b_adr_out;
   logic [BNCL*3-1:0]  b_cnt_out;
   logic [BNCL-1:0]    b_vpf_out;
   logic [4:0]         b_ncl_out;
`ifdef CLUSTER_DROP_CNT_EN
   logic [7:0] drop_cnt, b_drop_cnt;
`endif

   cluster_collector #(.NUM_ENCODERS(NE), .NUM_PASSES(NP), .SEG_SIZE(SEG),
                       .MXADRBITS(AW), .MXCNTBITS(CW)) dut (
      .clock(clock), .reset(reset), .enc_valid(enc_valid), .pass_in(pass_in),
      .adr_in(adr_in), .cnt_in(cnt_in), .vpf_in(vpf_in),
      .adr_out(adr_out), .cnt_out(cnt_out), .vpf_out(vpf_out), .ncl_out(ncl_out),
      .out_valid(out_valid), .out_ready(out_ready)
`ifdef CLUSTER_DROP_CNT_EN
      , .drop_cnt(drop_cnt)
`endif
   );

   cluster_collector #(.NUM_ENCODERS(BNE), .NUM_PASSES(BNP)) dut_b (
      .clock(clock), .reset(reset), .enc_valid(b_enc_valid), .pass_in(b_pass_in),
      .adr_in(b_adr_in), .cnt_in(b_cnt_in), .vpf_in(b_vpf_in),
      .adr_out(b_adr_out), .cnt_out(b_cnt_out), .vpf_out(b_vpf_out), .ncl_out(b_ncl_out),
      .out_valid(b_out_valid), .out_ready(b_out_ready)
`ifdef CLUSTER_DROP_CNT_EN
      , .drop_cnt(b_drop_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference model: partial frame per encoder/pass, plus the frame presented to the consumer.
   int acc_adr [NE][NP];
   int acc_cnt [NE][NP];
   bit acc_vpf [NE][NP];
   int m_adr [NCL];
   int m_cnt [NCL];
   bit m_vpf [NCL];
   bit m_valid;
   int m_drop;

   function automatic int gaddr(input int a, input bit v, input int e);
      return (a + (v ? e*SEG : 0)) % (1 << AW);
   endfunction

   task automatic clear_acc();
      for (int e = 0; e < NE; e++)
         for (int p = 0; p < NP; p++) begin
            acc_adr[e][p] = 0; acc_cnt[e][p] = 0; acc_vpf[e][p] = 0;
         end
   endtask

   task automatic model_step();
      bit done;
      int pi;
      if (reset) begin
         m_valid = 0; m_drop = 0;
         for (int k = 0; k < NCL; k++) begin m_adr[k] = 0; m_cnt[k] = 0; m_vpf[k] = 0; end
         clear_acc();
         return;
      end
      pi = int'(pass_in);
      done = enc_valid && (pi == NP-1);
      if (done) begin
         if (!m_valid || out_ready) begin
            for (int e = 0; e < NE; e++)
               for (int p = 0; p < NP; p++) begin
                  if (p == NP-1) begin
                     m_adr[e*NP+p] = gaddr(int'(adr_in[e*AW +: AW]), vpf_in[e], e);
                     m_cnt[e*NP+p] = int'(cnt_in[e*CW +: CW]);
                     m_vpf[e*NP+p] = vpf_in[e];
                  end else begin
                     m_adr[e*NP+p] = acc_adr[e][p];
                     m_cnt[e*NP+p] = acc_cnt[e][p];
                     m_vpf[e*NP+p] = acc_vpf[e][p];
                  end
               end
            m_valid = 1;
         end else if (m_drop < 255) begin
            m_drop++;
         end
         clear_acc();
      end else begin
         if (m_valid && out_ready) m_valid = 0;
         if (enc_valid && pi < NP)
            for (int e = 0; e < NE; e++) begin
               acc_adr[e][pi] = gaddr(int'(adr_in[e*AW +: AW]), vpf_in[e], e);
               acc_cnt[e][pi] = int'(cnt_in[e*CW +: CW]);
               acc_vpf[e][pi] = vpf_in[e];
            end
      end
   endtask

   task automatic check_outputs(input string tag);
      int n = 0;
      check_val({tag, ".valid"}, out_valid, m_valid);
      for (int k = 0; k < NCL; k++) begin
         check_val($sformatf("%s.adr%0d", tag, k), adr_out[k*AW +: AW], m_adr[k]);
         check_val($sformatf("%s.cnt%0d", tag, k), cnt_out[k*CW +: CW], m_cnt[k]);
         check_val($sformatf("%s.vpf%0d", tag, k), vpf_out[k], m_vpf[k]);
         n += m_vpf[k];
      end
      check_val({tag, ".ncl"}, ncl_out, n);
`ifdef CLUSTER_DROP_CNT_EN
      check_val({tag, ".drop"}, drop_cnt, m_drop);
`endif
   endtask

   task automatic drive(input bit v, input int pass, input int a0, input int c0, input bit f0,
                        input int a1, input int c1, input bit f1);
      enc_valid = v;
      pass_in   = 3'(pass);
      adr_in    = {AW'(a1), AW'(a0)};
      cnt_in    = {CW'(c1), CW'(c0)};
      vpf_in    = {f1, f0};
   endtask

   task automatic tick(input string tag);
      @(posedge clock);
      model_step();
      #1;
      check_outputs(tag);
   endtask

   initial begin
      reset = 1; out_ready = 0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      b_enc_valid = 0; b_out_ready = 1; b_pass_in = '0;
      b_adr_in = '0; b_cnt_in = '0; b_vpf_in = '0;
      tick("rst0"); tick("rst1");
      reset = 0;

      // Encoder 1 cluster at pass 0 gets the 768 segment offset.
      drive(1, 0, 0, 0, 0, 5, 2, 1); tick("f1p0");
      drive(1, 1, 0, 0, 0, 0, 0, 0); tick("f1p1");
      drive(1, 2, 0, 0, 0, 0, 0, 0); tick("f1p2");
      check_val("f1.pre_valid", out_valid, 0);
      drive(1, 3, 0, 0, 0, 0, 0, 0); tick("f1p3");
      check_val("f1.valid", out_valid, 1);
      check_val("f1.slot4_adr", adr_out[4*AW +: AW], 773);
      check_val("f1.ncl", ncl_out, 1);

      out_ready = 1; drive(0, 0, 0, 0, 0, 0, 0, 0); tick("hs1");
      check_val("hs1.valid", out_valid, 0);

      // Last pass comes straight from the inputs.
      out_ready = 0;
      drive(1, 3, 100, 7, 1, 0, 0, 0); tick("f2p3");
      check_val("f2.slot3_adr", adr_out[3*AW +: AW], 100);
      check_val("f2.slot3_cnt", cnt_out[3*CW +: CW], 7);
      check_val("f2.slot3_vpf", vpf_out[3], 1);

      // Completion while held and not ready: dropped.
      drive(1, 0, 0, 0, 0, 40, 1, 1); tick("f3p0");
      drive(1, 3, 0, 0, 0, 0, 0, 0); tick("f3drop");
      check_val("f3.valid", out_valid, 1);
      check_val("f3.slot3_adr", adr_out[3*AW +: AW], 100);
      check_val("f3.slot4_vpf", vpf_out[4], 0);
`ifdef CLUSTER_DROP_CNT_EN
      check_val("f3.drop_cnt", drop_cnt, 1);
`endif

      // Handshake coinciding with completion: no bubble.
      out_ready = 1;
      drive(1, 3, 9, 3, 1, 0, 0, 0); tick("f4");
      check_val("f4.valid", out_valid, 1);
      check_val("f4.slot3_adr", adr_out[3*AW +: AW], 9);
      drive(0, 0, 0, 0, 0, 0, 0, 0); tick("hs2");
      check_val("hs2.valid", out_valid, 0);

      // Reset mid-frame, then a clean frame right after.
      drive(1, 0, 0, 0, 0, 11, 1, 1); tick("f5p0");
      drive(1, 1, 0, 0, 0, 12, 1, 1); tick("f5p1");
      reset = 1; drive(0, 0, 0, 0, 0, 0, 0, 0); tick("midrst");
      check_val("midrst.ncl", ncl_out, 0);
      reset = 0;
      drive(1, 0, 0, 0, 0, 0, 0, 0); tick("f6p0");
      drive(1, 1, 0, 0, 0, 0, 0, 0); tick("f6p1");
      drive(1, 2, 33, 4, 1, 0, 0, 0); tick("f6p2");
      drive(1, 3, 0, 0, 0, 0, 0, 0); tick("f6p3");
      check_val("f6.slot2_adr", adr_out[2*AW +: AW], 33);
      check_val("f6.slot4_vpf", vpf_out[4], 0);
      check_val("f6.slot5_vpf", vpf_out[5], 0);
      check_val("f6.ncl", ncl_out, 1);

      for (int i = 0; i < 3000; i++) begin
         reset     = ($urandom_range(0, 199) == 0);
         out_ready = 1'($urandom_range(0, 1));
         enc_valid = ($urandom_range(0, 3) != 0);
         pass_in   = 3'($urandom_range(0, 5));
         adr_in    = (NE*AW)'($urandom);
         cnt_in    = (NE*CW)'($urandom);
         vpf_in    = NE'($urandom);
         tick("rnd");
      end
      reset = 0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);

      // Wider instance: 3 encoders, 8 passes, offset wraps.
      for (int p = 0; p < BNP; p++) begin
         b_enc_valid = 1; b_pass_in = 3'(p);
         b_adr_in = '0; b_cnt_in = '0; b_vpf_in = '0;
         if (p == 0) begin b_adr_in[22 +: 11] = 11'd767; b_vpf_in[2] = 1'b1; end
         if (p == 7) begin b_adr_in[22 +: 11] = 11'd10; b_cnt_in[6 +: 3] = 3'd5; b_vpf_in[2] = 1'b1; end
         @(posedge clock); #1;
         if (p < BNP-1) check_val($sformatf("b.pre_valid%0d", p), b_out_valid, 0);
      end
      b_enc_valid = 0;
      check_val("b.valid", b_out_valid, 1);
      check_val("b.slot16_adr", b_adr_out[16*11 +: 11], 255);
      check_val("b.slot16_vpf", b_vpf_out[16], 1);
      check_val("b.slot23_adr", b_adr_out[23*11 +: 11], 1546);
      check_val("b.slot23_cnt", b_cnt_out[23*3 +: 3], 5);
      check_val("b.slot0_vpf", b_vpf_out[0], 0);
      check_val("b.ncl", b_ncl_out, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
